// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the CPU/DMA data-memory arbiter.
// State encoding and burst limit used by arbiter and pick logic.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CPU_OWN   = 2'd1,
    ST_DMA_OWN   = 2'd2,
    ST_DMA_BURST = 2'd3
  } arb_state_t;

  localparam logic [3:0] BURST_LIMIT = 4'd8;

endpackage

// File: rtl/mem_bus_arbiter_pick.sv
// Combinational grant decision for the CPU/DMA arbiter.
// Produces one-hot grants from requests, state and counters.
module arb_pick
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       i_cpu_req,
  input  logic       i_dma_req,
  input  logic       i_dma_lock,
  input  arb_state_t i_state,
  input  logic [3:0] i_starve_cnt,
  input  logic [3:0] i_burst_cnt,
  output logic       o_cpu_gnt,
  output logic       o_dma_gnt
);

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  logic w_both;
  logic w_burst_hold;
  logic w_dma_first;

  assign w_both = i_cpu_req & i_dma_req;

  // An unexhausted locked burst beats the CPU; so does a starved DMA.
  assign w_burst_hold = (i_state == ST_DMA_BURST) & i_dma_lock
                      & (i_burst_cnt < BURST_LIMIT);
  assign w_dma_first  = w_burst_hold | (i_starve_cnt == LIM);

  always_comb begin
    o_cpu_gnt = 1'b0;
    o_dma_gnt = 1'b0;
    unique case (1'b1)
      w_both & w_dma_first:     o_dma_gnt = 1'b1;
      w_both & ~w_dma_first:    o_cpu_gnt = 1'b1;
      i_cpu_req & ~i_dma_req:   o_cpu_gnt = 1'b1;
      i_dma_req & ~i_cpu_req:   o_dma_gnt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port (CPU, DMA) arbiter onto a shared combinational-read memory.
// Holds FSM state, starvation/burst counters and per-port read data.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_rvalid,
  input  logic          dma_req,
  input  logic          dma_wr,
  input  logic [AW-1:0] dma_addr,
  input  logic [31:0]   dma_wdata,
  input  logic          dma_lock,
  output logic          dma_gnt,
  output logic [31:0]   dma_rdata,
  output logic          dma_rvalid,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  arb_state_t  r_state;
  logic [3:0]  r_starve_cnt;
  logic [3:0]  r_burst_cnt;
  logic [31:0] r_cpu_rdata;
  logic [31:0] r_dma_rdata;
  logic        r_cpu_rvalid;
  logic        r_dma_rvalid;

  logic        w_pick_cpu;
  logic        w_pick_dma;
  logic        w_cpu_gnt;
  logic        w_dma_gnt;
  logic [3:0]  w_burst_inc;

  arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .i_cpu_req    (cpu_req),
    .i_dma_req    (dma_req),
    .i_dma_lock   (dma_lock),
    .i_state      (r_state),
    .i_starve_cnt (r_starve_cnt),
    .i_burst_cnt  (r_burst_cnt),
    .o_cpu_gnt    (w_pick_cpu),
    .o_dma_gnt    (w_pick_dma)
  );

  assign w_cpu_gnt = reset & w_pick_cpu;
  assign w_dma_gnt = reset & w_pick_dma;

  assign w_burst_inc = (r_burst_cnt == BURST_LIMIT) ? r_burst_cnt
                                                    : r_burst_cnt + 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_starve_cnt <= '0;
      r_burst_cnt  <= '0;
      r_cpu_rdata  <= '0;
      r_dma_rdata  <= '0;
      r_cpu_rvalid <= 1'b0;
      r_dma_rvalid <= 1'b0;
    end else begin
      unique case (1'b1)
        w_dma_gnt: begin
          r_state     <= dma_lock ? ST_DMA_BURST : ST_DMA_OWN;
          r_burst_cnt <= dma_lock ? w_burst_inc : 4'd0;
        end
        w_cpu_gnt: begin
          r_state     <= ST_CPU_OWN;
          r_burst_cnt <= '0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_burst_cnt <= '0;
        end
      endcase

      if (w_dma_gnt | ~dma_req)
        r_starve_cnt <= '0;
      else if (w_cpu_gnt & (r_starve_cnt != LIM))
        r_starve_cnt <= r_starve_cnt + 4'd1;

      if (w_cpu_gnt & ~cpu_wr) r_cpu_rdata <= mem_rdata;
      if (w_dma_gnt & ~dma_wr) r_dma_rdata <= mem_rdata;
      r_cpu_rvalid <= w_cpu_gnt & ~cpu_wr;
      r_dma_rvalid <= w_dma_gnt & ~dma_wr;
    end
  end

  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      w_cpu_gnt: begin
        mem_rd    = ~cpu_wr;
        mem_wr    = cpu_wr;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      w_dma_gnt: begin
        mem_rd    = ~dma_wr;
        mem_wr    = dma_wr;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
      end
      default: ;
    endcase
  end

  assign cpu_gnt    = w_cpu_gnt;
  assign dma_gnt    = w_dma_gnt;
  assign cpu_stall  = cpu_req & ~w_cpu_gnt;
  assign cpu_rdata  = r_cpu_rdata;
  assign cpu_rvalid = r_cpu_rvalid;
  assign dma_rdata  = r_dma_rdata;
  assign dma_rvalid = r_dma_rvalid;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: reset, zero-wait read,
// starvation rotation, locked burst, DMA write, reset mid-read.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dma_req, dma_wr, dma_lock;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  mem_bus_arbiter #(
    .STARVE_LIMIT (4),
    .AW           (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_stall  (cpu_stall),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .dma_req    (dma_req),
    .dma_wr     (dma_wr),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_lock   (dma_lock),
    .dma_gnt    (dma_gnt),
    .dma_rdata  (dma_rdata),
    .dma_rvalid (dma_rvalid),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    cpu_req = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_wr = 0; dma_addr = '0; dma_wdata = '0;
    dma_lock = 0; mem_rdata = '0;

    // Reset: state cleared, grants forced low even with a request
    tick();
    cpu_req = 1;
    #1;
    chk1("rst_cpu_gnt", cpu_gnt, 1'b0);
    chk1("rst_dma_gnt", dma_gnt, 1'b0);
    chk1("rst_mem_rd", mem_rd, 1'b0);
    chk1("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    chk1("rst_dma_rvalid", dma_rvalid, 1'b0);
    chk32("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk32("rst_dma_rdata", dma_rdata, 32'h0);
    cpu_req = 0;
    tick();
    reset = 1'b1;

    // CPU-only read, zero-wait grant, data next cycle
    cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h10;
    mem_rdata = 32'hDEADBEEF;
    #1;
    chk1("rd_cpu_gnt", cpu_gnt, 1'b1);
    chk1("rd_cpu_stall", cpu_stall, 1'b0);
    chk1("rd_mem_rd", mem_rd, 1'b1);
    chk32("rd_mem_addr", mem_addr, 32'h10);
    tick();
    cpu_req = 0;
    mem_rdata = 32'h0;
    #1;
    chk1("rd_cpu_rvalid", cpu_rvalid, 1'b1);
    chk32("rd_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    chk1("rd_stall_after", cpu_stall, 1'b0);
    chk1("rd_idle_mem_rd", mem_rd, 1'b0);
    chk32("rd_idle_addr", mem_addr, 32'h0);
    tick();
    chk1("rd_rvalid_drop", cpu_rvalid, 1'b0);
    chk32("rd_rdata_hold", cpu_rdata, 32'hDEADBEEF);

    // Starvation rotation: C,C,C,C,D repeating
    cpu_req = 1; dma_req = 1; dma_wr = 0; dma_lock = 0;
    cpu_addr = 32'h20; dma_addr = 32'h30;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk1("rot_cpu_gnt", cpu_gnt, (i % 5) != 4);
      chk1("rot_dma_gnt", dma_gnt, (i % 5) == 4);
      chk1("rot_stall", cpu_stall, (i % 5) == 4);
      chk32("rot_addr", mem_addr, ((i % 5) == 4) ? 32'h30 : 32'h20);
      tick();
    end
    cpu_req = 0; dma_req = 0;

    // DMA write while CPU idle: no read valid
    dma_req = 1; dma_wr = 1; dma_addr = 32'h40000000;
    dma_wdata = 32'h55;
    #1;
    chk1("wr_dma_gnt", dma_gnt, 1'b1);
    chk1("wr_mem_wr", mem_wr, 1'b1);
    chk1("wr_mem_rd", mem_rd, 1'b0);
    chk32("wr_mem_addr", mem_addr, 32'h40000000);
    chk32("wr_mem_wdata", mem_wdata, 32'h55);
    tick();
    dma_req = 0; dma_wr = 0; dma_wdata = '0;
    #1;
    chk1("wr_dma_rvalid", dma_rvalid, 1'b0);
    chk1("wr_idle_mem_wr", mem_wr, 1'b0);
    tick();

    // Locked burst: 8 DMA, 1 CPU, then DMA resumes
    dma_req = 1; dma_lock = 1;
    for (int i = 0; i < 12; i++) begin
      cpu_req = (i >= 1) && (i <= 8);
      #1;
      chk1("bst_dma_gnt", dma_gnt, i != 8);
      chk1("bst_cpu_gnt", cpu_gnt, i == 8);
      chk1("bst_onehot", cpu_gnt & dma_gnt, 1'b0);
      tick();
    end
    cpu_req = 0; dma_req = 0; dma_lock = 0;
    tick();

    // Reset in the cycle after a DMA read grant
    dma_req = 1; dma_wr = 0; dma_addr = 32'h80;
    mem_rdata = 32'h12345678;
    #1;
    chk1("rr_dma_gnt", dma_gnt, 1'b1);
    tick();
    mem_rdata = 32'h0;
    chk1("rr_dma_rvalid", dma_rvalid, 1'b1);
    chk32("rr_dma_rdata", dma_rdata, 32'h12345678);
    reset = 1'b0;
    #1;
    chk1("rr_rvalid_clr", dma_rvalid, 1'b0);
    chk32("rr_rdata_clr", dma_rdata, 32'h0);
    chk1("rr_dma_gnt_rst", dma_gnt, 1'b0);
    chk1("rr_mem_rd_rst", mem_rd, 1'b0);
    tick();
    dma_req = 0;
    cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h44;
    mem_rdata = 32'hCAFE0001;
    tick();
    reset = 1'b1;
    #1;
    chk1("rr_cpu_first", cpu_gnt, 1'b1);
    chk1("rr_cpu_stall", cpu_stall, 1'b0);
    tick();
    cpu_req = 0;
    chk1("rr_cpu_rvalid", cpu_rvalid, 1'b1);
    chk32("rr_cpu_rdata", cpu_rdata, 32'hCAFE0001);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
